// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Imported by fetch_unit and fetch_out_reg.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
    logic [31:0]        pc_plus4;
  } fetch_out_t;

endpackage

// File: rtl/fetch_out_reg.sv
// Single-entry output register between fetch and decode.
// Flush wins over load; contents hold while neither is asserted.
module fetch_out_reg
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       flush,
  input  fetch_out_t d,
  output logic       valid,
  output fetch_out_t q
);

  logic       valid_d, valid_q;
  fetch_out_t data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q         <= 1'b0;
      data_q.instr    <= NOP_INSTR;
      data_q.pc       <= 32'd0;
      data_q.pc_plus4 <= PC_STEP;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign q     = data_q;

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: owns the PC, drives imem, registers the
// fetched instruction for decode and traps bad fetch addresses.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          IMEM_DEPTH  = 256,
  parameter int          INSTR_WIDTH = INSTR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [31:0]            imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_instr,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_pc_plus4,
  output logic                   fault,
  output logic [31:0]            fault_pc,
  output logic [31:0]            fetch_count
);

  localparam logic [31:0] DEPTH = 32'(IMEM_DEPTH);

  fetch_state_t state_d, state_q;
  logic [31:0]  pc_d, pc_q;
  logic [31:0]  fault_pc_d, fault_pc_q;
  logic [31:0]  count_d, count_q;

  logic       take, slot_free, pc_oor;
  logic       load, flush;
  fetch_out_t fetched, held;

  assign take      = out_valid && out_ready;
  assign slot_free = !out_valid || take;
  assign pc_oor    = {2'b00, pc_q[31:2]} >= DEPTH;

  assign fetched.instr    = imem_instr;
  assign fetched.pc       = pc_q;
  assign fetched.pc_plus4 = pc_q + PC_STEP;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_pc_d = fault_pc_q;
    count_d    = count_q + {31'd0, take};
    load       = 1'b0;
    flush      = 1'b0;
    unique case (state_q)
      RUN: begin
        if (redirect_valid && redirect_pc[1:0] != 2'b00) begin
          state_d    = FAULT;
          fault_pc_d = redirect_pc;
          flush      = 1'b1;
        end else if (redirect_valid) begin
          pc_d  = redirect_pc;
          flush = 1'b1;
        end else if (slot_free && pc_oor) begin
          state_d    = FAULT;
          fault_pc_d = pc_q;
          flush      = 1'b1;
        end else if (slot_free) begin
          load = 1'b1;
          pc_d = pc_q + PC_STEP;
        end
      end
      FAULT: begin
        flush = 1'b1;
      end
      default: begin
        state_d = FAULT;
        flush   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      fault_pc_q <= 32'd0;
      count_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_pc_q <= fault_pc_d;
      count_q    <= count_d;
    end
  end

  fetch_out_reg u_out_reg (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .flush (flush),
    .d     (fetched),
    .valid (out_valid),
    .q     (held)
  );

  assign imem_addr    = {2'b00, pc_q[31:2]};
  assign out_instr    = held.instr;
  assign out_pc       = held.pc;
  assign out_pc_plus4 = held.pc_plus4;
  assign fault        = (state_q == FAULT);
  assign fault_pc     = fault_pc_q;
  assign fetch_count  = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected handshakes are queued
// up front and a monitor pops one on every out_valid&&out_ready.
module tb_fetch_unit;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_count;

  logic [31:0] mem [256];
  exp_t        sb [$];
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  assign imem_instr = (imem_addr < 32'd256) ? mem[imem_addr[7:0]] : 32'hDEAD_BEEF;

  fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .IMEM_DEPTH  (256),
    .INSTR_WIDTH (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4),
    .fault          (fault),
    .fault_pc       (fault_pc),
    .fetch_count    (fetch_count)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted output must match the head of the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_take_pc", out_pc, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("sb_instr", out_instr, e.instr);
          chk("sb_pc", out_pc, e.pc);
          chk("sb_pc_plus4", out_pc_plus4, e.pc + 32'd4);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013 | (i << 16);
    mem[0] = 32'h0000_8033;
    mem[1] = 32'h4000_8033;
    sb.push_back('{32'h0000_8033, 32'h0000_0000});
    sb.push_back('{32'h4000_8033, 32'h0000_0004});
    sb.push_back('{32'h0002_0013, 32'h0000_0008});
    sb.push_back('{32'h0010_0013, 32'h0000_0040});
    sb.push_back('{32'h00FF_0013, 32'h0000_03FC});

    rst = 1'b1;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    tick;
    tick;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_instr", out_instr, 32'h0000_0013);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_pc4", out_pc_plus4, 32'd4);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_fault_pc", fault_pc, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);

    rst = 1'b0;
    tick;
    chk("e1_valid", {31'd0, out_valid}, 32'd1);
    tick;
    chk("e2_pc", out_pc, 32'd4);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("stall_pc", out_pc, 32'd4);
      chk("stall_instr", out_instr, 32'h4000_8033);
      chk("stall_addr", imem_addr, 32'd2);
      chk("stall_count", fetch_count, 32'd1);
    end
    out_ready = 1'b1;
    tick;
    chk("unstall_pc", out_pc, 32'd8);
    chk("unstall_count", fetch_count, 32'd2);

    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    tick;
    chk("redir_valid", {31'd0, out_valid}, 32'd0);
    chk("redir_count", fetch_count, 32'd3);
    redirect_valid = 1'b0;
    tick;
    chk("redir_tgt_pc", out_pc, 32'h40);
    chk("redir_tgt_instr", out_instr, 32'h0010_0013);

    redirect_valid = 1'b1;
    redirect_pc = 32'h42;
    tick;
    chk("mis_fault", {31'd0, fault}, 32'd1);
    chk("mis_fault_pc", fault_pc, 32'h42);
    chk("mis_valid", {31'd0, out_valid}, 32'd0);
    chk("mis_count", fetch_count, 32'd4);
    redirect_pc = 32'h0;
    tick;
    tick;
    redirect_valid = 1'b0;
    chk("flt_sticky", {31'd0, fault}, 32'd1);
    chk("flt_first_pc", fault_pc, 32'h42);
    chk("flt_valid", {31'd0, out_valid}, 32'd0);
    chk("flt_pc_frozen", imem_addr, 32'h11);

    #2 rst = 1'b1;
    #1;
    chk("clr_fault", {31'd0, fault}, 32'd0);
    chk("clr_addr", imem_addr, 32'd0);
    tick;
    redirect_valid = 1'b1;
    redirect_pc = 32'h3FC;
    rst = 1'b0;
    tick;
    chk("oor_flush", {31'd0, out_valid}, 32'd0);
    redirect_valid = 1'b0;
    tick;
    chk("oor_last_pc", out_pc, 32'h3FC);
    tick;
    chk("oor_fault", {31'd0, fault}, 32'd1);
    chk("oor_fault_pc", fault_pc, 32'h400);
    chk("oor_valid", {31'd0, out_valid}, 32'd0);
    chk("oor_count", fetch_count, 32'd1);

    rst = 1'b1;
    tick;
    rst = 1'b0;
    out_ready = 1'b0;
    tick;
    tick;
    chk("ms_valid", {31'd0, out_valid}, 32'd1);
    chk("ms_addr", imem_addr, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_instr", out_instr, 32'h0000_0013);
    chk("arst_addr", imem_addr, 32'd0);
    chk("arst_count", fetch_count, 32'd0);
    @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
